change_dispenser_ctrl: RTL and testbench
========================================

# change_dispenser_ctrl

Sequencer for coin change payout in the vending controller. On a start strobe it snapshots the nickel, dime and quarter inventory counts and the change owed. It then issues coin-eject requests one at a time to the coin mechanism, using a valid/ack handshake and greedy largest-coin-first selection. It reports completion, any shortfall, and the amount left unpaid; the inventory counter blocks decrement their own counts from the same eject handshake.

## Interface
Parameters:
- COUNT_W, 8, width of inventory counts and change amount.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  begin payout; sampled only in IDLE.
- changeAmount  input  COUNT_W  change owed in cents.
- nickelCount, dimeCount, quarterCount  input  COUNT_W each  current inventory.
- coinAck  input  1  mechanism accepted the current coin request.
- coinValid  output  1  coin request pending.
- coinType  output  2  01 nickel, 10 dime, 11 quarter; 00 whenever coinValid=0.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.
- short  output  1  payout ended with remaining != 0; held until next accepted start.
- remaining  output  COUNT_W  cents still owed; held until next accepted start.

## Operation
- States: IDLE, LOAD, SELECT, REQ, FINISH.
- IDLE → LOAD when start=1.
- LOAD: latch changeAmount into remaining and the three counts into local copies (nLeft, dLeft, qLeft); clear short.
- SELECT:
  - if remaining ≥ 25 and qLeft > 0 → quarter;
  - else if remaining ≥ 10 and dLeft > 0 → dime;
  - else if remaining ≥ 5 and nLeft > 0 → nickel.
  - Coin chosen → REQ with coinType latched; no coin possible (including remaining=0) → FINISH.
- REQ: coinValid=1 and coinType stable until coinAck.
  - On the coinAck cycle: subtract the coin value from remaining, decrement that local count, → SELECT.
  - coinAck outside REQ is ignored.
- FINISH: done=1 for one cycle, short = (remaining != 0), → IDLE.
- Greedy only. Combinations solvable only non-greedily (30¢ with 1Q, 3D, 0N) end short; this is the decided behaviour.
- Amounts not a multiple of 5 end short with remaining = residue (1–4).
- Inventory inputs are ignored after LOAD. Changes during payout do not affect the current payout.
- start while busy is ignored; it is not queued.
- Reset at any time: state to IDLE, coinValid=0, coinType=00, busy=0, done=0, short=0, remaining=0, local counts 0. A request in flight is abandoned without decrement.

## Timing
- start accepted at cycle T. LOAD at T+1, SELECT at T+2, first coinValid at T+3.
- Each coin takes 1 SELECT cycle plus ≥1 REQ cycle; coinAck tied high gives 2 cycles per coin.
- done asserts the cycle after the SELECT that finds no coin. remaining and short are valid in the same cycle as done.
- All outputs are registered. coinValid never drops without coinAck except on reset.
- Width rule: remaining never underflows, because selection guarantees remaining ≥ coin value.
- Local counts saturate at 0, which selection also guarantees.

## Structure
- Shared package change_pkg holds:
  - coin type codes COIN_NONE/NICKEL/DIME/QUARTER;
  - coin values 5/10/25;
  - state enum;
  - the COUNT_W default.
- Sub-module change_coin_select: combinational greedy selector. Inputs are remaining, nLeft, dLeft and qLeft; outputs are coinType and coinValue (coinType = COIN_NONE when no coin fits). It is instantiated once in SELECT decode.
- The FSM and datapath registers live in change_dispenser_ctrl.

## Test plan
- changeAmount=40, counts 10/10/10, coinAck tied high → Q, D, N requests, done at T+9, short=0, remaining=0.
- changeAmount=30, counts N=6/D=0/Q=0, coinAck delayed 3 cycles each → six nickel requests with coinType held through each wait, short=0.
- changeAmount=30, counts N=0/D=3/Q=1 → one quarter, then done with short=1, remaining=5.
- changeAmount=0 → no coinValid, done at T+3, short=0. changeAmount=3 → no coins, short=1, remaining=3.
- Reset asserted mid-REQ during a 45¢ payout → coinValid and busy drop immediately. A later start with 15¢ pays D, N cleanly.
- start pulsed while busy, and coinAck pulsed in IDLE → both ignored; request count and remaining are unaffected.

Source files
------------

// File: rtl/change_pkg.sv
// Shared definitions for the change payout sequencer: coin codes, coin values,
// FSM states and the default inventory/amount width.
package change_pkg;

  localparam int DEFAULT_COUNT_W = 8;

  localparam logic [1:0] COIN_NONE    = 2'b00;
  localparam logic [1:0] COIN_NICKEL  = 2'b01;
  localparam logic [1:0] COIN_DIME    = 2'b10;
  localparam logic [1:0] COIN_QUARTER = 2'b11;

  localparam int unsigned VAL_NICKEL  = 5;
  localparam int unsigned VAL_DIME    = 10;
  localparam int unsigned VAL_QUARTER = 25;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SELECT,
    ST_REQ,
    ST_FINISH
  } state_t;

endpackage

// File: rtl/change_coin_select.sv
// Greedy largest-coin-first selector; purely combinational.
// Reports COIN_NONE with a zero value when no stocked coin fits the amount.
module change_coin_select
  import change_pkg::*;
#(
  parameter int W = DEFAULT_COUNT_W
) (
  input  logic [W-1:0] remaining_i,
  input  logic [W-1:0] n_left_i,
  input  logic [W-1:0] d_left_i,
  input  logic [W-1:0] q_left_i,
  output logic [1:0]   coin_type_o,
  output logic [W-1:0] coin_value_o
);

  always_comb begin
    coin_type_o  = COIN_NONE;
    coin_value_o = '0;
    if (remaining_i >= W'(VAL_QUARTER) && q_left_i != '0) begin
      coin_type_o  = COIN_QUARTER;
      coin_value_o = W'(VAL_QUARTER);
    end else if (remaining_i >= W'(VAL_DIME) && d_left_i != '0) begin
      coin_type_o  = COIN_DIME;
      coin_value_o = W'(VAL_DIME);
    end else if (remaining_i >= W'(VAL_NICKEL) && n_left_i != '0) begin
      coin_type_o  = COIN_NICKEL;
      coin_value_o = W'(VAL_NICKEL);
    end
  end

endmodule

// File: rtl/change_dispenser_ctrl.sv
// Coin payout sequencer: snapshots inventory and amount on start, then ejects
// coins one at a time over a valid/ack handshake; all outputs registered.
module change_dispenser_ctrl
  import change_pkg::*;
#(
  parameter int COUNT_W = DEFAULT_COUNT_W
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic [COUNT_W-1:0] changeAmount,
  input  logic [COUNT_W-1:0] nickelCount,
  input  logic [COUNT_W-1:0] dimeCount,
  input  logic [COUNT_W-1:0] quarterCount,
  input  logic               coinAck,
  output logic               coinValid,
  output logic [1:0]         coinType,
  output logic               busy,
  output logic               done,
  output logic               short,
  output logic [COUNT_W-1:0] remaining
);

  state_t             state_q;
  logic [COUNT_W-1:0] remaining_q;
  logic [COUNT_W-1:0] n_left_q;
  logic [COUNT_W-1:0] d_left_q;
  logic [COUNT_W-1:0] q_left_q;
  logic [COUNT_W-1:0] coin_value_q;
  logic [1:0]         coin_type_q;
  logic               coin_valid_q;
  logic               busy_q;
  logic               done_q;
  logic               short_q;

  logic [1:0]         sel_type;
  logic [COUNT_W-1:0] sel_value;

  change_coin_select #(
    .W (COUNT_W)
  ) u_select (
    .remaining_i  (remaining_q),
    .n_left_i     (n_left_q),
    .d_left_i     (d_left_q),
    .q_left_i     (q_left_q),
    .coin_type_o  (sel_type),
    .coin_value_o (sel_value)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      remaining_q  <= '0;
      n_left_q     <= '0;
      d_left_q     <= '0;
      q_left_q     <= '0;
      coin_value_q <= '0;
      coin_type_q  <= COIN_NONE;
      coin_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      short_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            busy_q  <= 1'b1;
            short_q <= 1'b0;
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          remaining_q <= changeAmount;
          n_left_q    <= nickelCount;
          d_left_q    <= dimeCount;
          q_left_q    <= quarterCount;
          state_q     <= ST_SELECT;
        end
        ST_SELECT: begin
          if (sel_type != COIN_NONE) begin
            coin_type_q  <= sel_type;
            coin_value_q <= sel_value;
            coin_valid_q <= 1'b1;
            state_q      <= ST_REQ;
          end else begin
            // done and short are raised together so both appear in FINISH
            done_q  <= 1'b1;
            short_q <= (remaining_q != '0);
            state_q <= ST_FINISH;
          end
        end
        ST_REQ: begin
          if (coinAck) begin
            remaining_q  <= remaining_q - coin_value_q;
            coin_valid_q <= 1'b0;
            coin_type_q  <= COIN_NONE;
            case (coin_type_q)
              COIN_NICKEL:  n_left_q <= n_left_q - 1'b1;
              COIN_DIME:    d_left_q <= d_left_q - 1'b1;
              COIN_QUARTER: q_left_q <= q_left_q - 1'b1;
              default:      ;
            endcase
            state_q <= ST_SELECT;
          end
        end
        ST_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign coinValid = coin_valid_q;
  assign coinType  = coin_type_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign short     = short_q;
  assign remaining = remaining_q;

endmodule

// File: tb/tb_change_dispenser_ctrl.sv
// Bench for change_dispenser_ctrl: directed scenarios plus randomized payouts
// compared against an arithmetic greedy-change model.
module tb_change_dispenser_ctrl;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       start = 1'b0;
  logic       coinAck = 1'b0;
  logic [7:0] changeAmount = '0;
  logic [7:0] nickelCount = '0;
  logic [7:0] dimeCount = '0;
  logic [7:0] quarterCount = '0;
  logic       coinValid;
  logic [1:0] coinType;
  logic       busy;
  logic       done;
  logic       short;
  logic [7:0] remaining;

  int errors = 0;
  int checks = 0;

  change_dispenser_ctrl #(.COUNT_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .changeAmount (changeAmount),
    .nickelCount  (nickelCount),
    .dimeCount    (dimeCount),
    .quarterCount (quarterCount),
    .coinAck      (coinAck),
    .coinValid    (coinValid),
    .coinType     (coinType),
    .busy         (busy),
    .done         (done),
    .short        (short),
    .remaining    (remaining)
  );

  always #5 clock = ~clock;

  logic [1:0] obs_coins[$];
  logic [1:0] exp_coins[$];
  int         obs_done_edge;
  logic       obs_short;
  logic [7:0] obs_rem;
  int         obs_proto;
  bit         obs_timeout;
  logic [7:0] exp_rem;
  logic       exp_short;

  // Greedy change computed with division: how many of each coin fit.
  task automatic model(input int amt, input int n, input int d, input int q);
    int nq, nd, nn;
    exp_coins.delete();
    nq = amt / 25; if (nq > q) nq = q; amt -= 25 * nq;
    nd = amt / 10; if (nd > d) nd = d; amt -= 10 * nd;
    nn = amt / 5;  if (nn > n) nn = n; amt -= 5 * nn;
    repeat (nq) exp_coins.push_back(2'b11);
    repeat (nd) exp_coins.push_back(2'b10);
    repeat (nn) exp_coins.push_back(2'b01);
    exp_rem   = 8'(amt);
    exp_short = (amt != 0);
  endtask

  // Drives one payout; ack_delay<0 picks a random 0..3 wait per coin.
  // e counts negedges after the accepting edge (e=0 is the LOAD cycle).
  task automatic run_payout(input int amt, input int n, input int d, input int q,
                            input int ack_delay, input bit poke_start);
    int w, dly;
    logic pend;
    logic [1:0] ptype;
    obs_coins.delete();
    obs_proto = 0; obs_timeout = 1; obs_done_edge = -1;
    obs_short = 1'bx; obs_rem = 'x;
    w = 0; pend = 0; ptype = 2'b00;
    dly = (ack_delay < 0) ? int'($urandom_range(0, 3)) : ack_delay;
    @(negedge clock);
    changeAmount = 8'(amt); nickelCount = 8'(n); dimeCount = 8'(d); quarterCount = 8'(q);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int e = 0; e < 400; e++) begin
      if (e == 1) begin
        changeAmount = 8'($urandom); nickelCount = 8'($urandom);
        dimeCount = 8'($urandom); quarterCount = 8'($urandom);
      end
      if (poke_start) start = (e == 3);
      if (busy !== 1'b1) obs_proto++;
      if (pend && (coinValid !== 1'b1 || coinType !== ptype)) obs_proto++;
      if (coinValid !== 1'b1 && coinType !== 2'b00) obs_proto++;
      if (coinValid === 1'b1) begin
        if (coinType === 2'b00) obs_proto++;
        pend = 1'b1; ptype = coinType;
        if (w >= dly) begin
          coinAck = 1'b1;
          obs_coins.push_back(coinType);
          pend = 1'b0; w = 0;
          if (ack_delay < 0) dly = $urandom_range(0, 3);
        end else begin
          coinAck = 1'b0;
          w++;
        end
      end else begin
        coinAck = (ack_delay == 0);
      end
      if (done === 1'b1) begin
        obs_done_edge = e; obs_short = short; obs_rem = remaining; obs_timeout = 0;
        break;
      end
      @(negedge clock);
    end
    coinAck = 1'b0;
    start = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    #12;
    checks++; if (coinValid !== 1'b0) begin errors++; $display("FAIL reset_coinValid got=%b want=0", coinValid); end
    checks++; if (coinType !== 2'b00) begin errors++; $display("FAIL reset_coinType got=%b want=00", coinType); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (short !== 1'b0) begin errors++; $display("FAIL reset_short got=%b want=0", short); end
    checks++; if (remaining !== 8'd0) begin errors++; $display("FAIL reset_remaining got=%0d want=0", remaining); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_tied_high;
    model(40, 10, 10, 10);
    run_payout(40, 10, 10, 10, 0, 0);
    checks++; if (obs_timeout) begin errors++; $display("FAIL tied_timeout got=no_done want=done"); end
    checks++; if (obs_coins.size() != exp_coins.size()) begin errors++; $display("FAIL tied_count got=%0d want=%0d", obs_coins.size(), exp_coins.size()); end
    for (int i = 0; i < exp_coins.size() && i < obs_coins.size(); i++) begin
      checks++; if (obs_coins[i] !== exp_coins[i]) begin errors++; $display("FAIL tied_coin%0d got=%b want=%b", i, obs_coins[i], exp_coins[i]); end
    end
    checks++; if (obs_done_edge != 8) begin errors++; $display("FAIL tied_done_time got=T+%0d want=T+9", obs_done_edge + 1); end
    checks++; if (obs_short !== 1'b0) begin errors++; $display("FAIL tied_short got=%b want=0", obs_short); end
    checks++; if (obs_rem !== 8'd0) begin errors++; $display("FAIL tied_remaining got=%0d want=0", obs_rem); end
    checks++; if (obs_proto != 0) begin errors++; $display("FAIL tied_protocol got=%0d want=0", obs_proto); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL tied_busy_after got=%b want=0", busy); end
  endtask

  task automatic test_delayed_ack;
    run_payout(30, 6, 0, 0, 3, 0);
    checks++; if (obs_coins.size() != 6) begin errors++; $display("FAIL delayed_count got=%0d want=6", obs_coins.size()); end
    for (int i = 0; i < obs_coins.size(); i++) begin
      checks++; if (obs_coins[i] !== 2'b01) begin errors++; $display("FAIL delayed_coin%0d got=%b want=01", i, obs_coins[i]); end
    end
    checks++; if (obs_short !== 1'b0 || obs_rem !== 8'd0) begin errors++; $display("FAIL delayed_result got=short%b/rem%0d want=short0/rem0", obs_short, obs_rem); end
    checks++; if (obs_proto != 0) begin errors++; $display("FAIL delayed_hold got=%0d want=0", obs_proto); end
  endtask

  task automatic test_greedy_short;
    run_payout(30, 0, 3, 1, 1, 0);
    checks++; if (obs_coins.size() != 1 || obs_coins[0] !== 2'b11) begin errors++; $display("FAIL greedy_coins got=%0d_coins want=1_quarter", obs_coins.size()); end
    checks++; if (obs_short !== 1'b1) begin errors++; $display("FAIL greedy_short got=%b want=1", obs_short); end
    checks++; if (obs_rem !== 8'd5) begin errors++; $display("FAIL greedy_remaining got=%0d want=5", obs_rem); end
  endtask

  task automatic test_zero_and_residue;
    run_payout(0, 4, 4, 4, 0, 0);
    checks++; if (obs_coins.size() != 0) begin errors++; $display("FAIL zero_count got=%0d want=0", obs_coins.size()); end
    checks++; if (obs_done_edge != 2) begin errors++; $display("FAIL zero_done_time got=T+%0d want=T+3", obs_done_edge + 1); end
    checks++; if (obs_short !== 1'b0) begin errors++; $display("FAIL zero_short got=%b want=0", obs_short); end
    run_payout(3, 4, 4, 4, 0, 0);
    checks++; if (obs_coins.size() != 0) begin errors++; $display("FAIL residue_count got=%0d want=0", obs_coins.size()); end
    checks++; if (obs_short !== 1'b1 || obs_rem !== 8'd3) begin errors++; $display("FAIL residue_result got=short%b/rem%0d want=short1/rem3", obs_short, obs_rem); end
  endtask

  task automatic test_reset_mid_req;
    bit seen;
    seen = 0;
    @(negedge clock);
    changeAmount = 8'd45; nickelCount = 8'd10; dimeCount = 8'd10; quarterCount = 8'd10;
    coinAck = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (coinValid === 1'b1) seen = 1;
      else @(negedge clock);
    end
    checks++; if (!seen) begin errors++; $display("FAIL midreq_timeout got=no_coinValid want=coinValid"); end
    #2 reset = 1'b0;
    #1;
    checks++; if (coinValid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL midreq_drop got=valid%b/busy%b want=valid0/busy0", coinValid, busy); end
    checks++; if (remaining !== 8'd0 || coinType !== 2'b00) begin errors++; $display("FAIL midreq_clear got=rem%0d/type%b want=rem0/type00", remaining, coinType); end
    @(negedge clock);
    reset = 1'b1;
    run_payout(15, 10, 10, 10, 0, 0);
    checks++; if (obs_coins.size() != 2) begin errors++; $display("FAIL after_reset_count got=%0d want=2", obs_coins.size()); end
    else begin
      checks++; if (obs_coins[0] !== 2'b10 || obs_coins[1] !== 2'b01) begin errors++; $display("FAIL after_reset_seq got=%b,%b want=10,01", obs_coins[0], obs_coins[1]); end
    end
    checks++; if (obs_short !== 1'b0 || obs_rem !== 8'd0) begin errors++; $display("FAIL after_reset_result got=short%b/rem%0d want=short0/rem0", obs_short, obs_rem); end
  endtask

  task automatic test_ignored_inputs;
    bit bad;
    bad = 0;
    model(12, 1, 0, 0);
    run_payout(12, 1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      coinAck = 1'b1;
      @(negedge clock);
      if (coinValid !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    coinAck = 1'b0;
    checks++; if (bad) begin errors++; $display("FAIL idle_ack got=activity want=none"); end
    checks++; if (remaining !== exp_rem) begin errors++; $display("FAIL idle_ack_rem got=%0d want=%0d", remaining, exp_rem); end
    model(70, 5, 5, 5);
    run_payout(70, 5, 5, 5, 2, 1);
    checks++; if (obs_coins.size() != exp_coins.size()) begin errors++; $display("FAIL busy_start_count got=%0d want=%0d", obs_coins.size(), exp_coins.size()); end
    checks++; if (obs_rem !== exp_rem) begin errors++; $display("FAIL busy_start_rem got=%0d want=%0d", obs_rem, exp_rem); end
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      if (busy !== 1'b0 || coinValid !== 1'b0) bad = 1;
      @(negedge clock);
    end
    checks++; if (bad) begin errors++; $display("FAIL busy_start_queued got=restarted want=idle"); end
  endtask

  task automatic test_random;
    int amt, n, d, q;
    bit seq_ok;
    for (int k = 0; k < 30; k++) begin
      amt = $urandom_range(0, 120);
      n = $urandom_range(0, 4); d = $urandom_range(0, 4); q = $urandom_range(0, 4);
      model(amt, n, d, q);
      run_payout(amt, n, d, q, -1, 0);
      seq_ok = (obs_coins.size() == exp_coins.size());
      for (int i = 0; seq_ok && i < exp_coins.size(); i++)
        if (obs_coins[i] !== exp_coins[i]) seq_ok = 0;
      checks++; if (!seq_ok) begin errors++; $display("FAIL rand%0d_seq amt=%0d n=%0d d=%0d q=%0d got=%0d_coins want=%0d_coins", k, amt, n, d, q, obs_coins.size(), exp_coins.size()); end
      checks++; if (obs_rem !== exp_rem || obs_short !== exp_short) begin errors++; $display("FAIL rand%0d_result got=rem%0d/short%b want=rem%0d/short%b", k, obs_rem, obs_short, exp_rem, exp_short); end
      checks++; if (obs_proto != 0 || obs_timeout) begin errors++; $display("FAIL rand%0d_protocol got=%0d/timeout%0d want=0/0", k, obs_proto, obs_timeout); end
    end
  endtask

  initial begin
    test_reset();
    test_tied_high();
    test_delayed_ack();
    test_greedy_short();
    test_zero_and_residue();
    test_reset_mid_req();
    test_ignored_inputs();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
